// File: rtl/hwpe_ctrl_ucode_sched.sv
// Job scheduler for the HWPE microcode loop engine: steps the engine, buffers each
// flags-valid update in a one-entry slot and hands it to the streamer control.
module hwpe_ctrl_ucode_sched #(
    parameter int unsigned NB_REG    = 4,
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [CNT_WIDTH-1:0]        nb_updates_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        ucode_clear_o,
    output logic                        ucode_enable_o,
    input  logic                        ucode_valid_i,
    input  logic                        ucode_done_i,
    input  logic                        ucode_accum_i,
    input  logic [NB_REG*REG_WIDTH-1:0] ucode_offs_i,
    output logic                        upd_valid_o,
    input  logic                        upd_ready_i,
    output logic [NB_REG*REG_WIDTH-1:0] upd_offs_o,
    output logic                        upd_accum_o,
    output logic                        upd_last_o,
    output logic [CNT_WIDTH-1:0]        upd_count_o
);

    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_WIDTH-1:0] limit_r;
    logic [CNT_WIDTH-1:0] count_inc_s;
    logic [WD_W-1:0]      wd_r;
    logic                 wd_expire_s;
    logic                 last_s;

    assign count_inc_s = upd_count_o + CNT_WIDTH'(1);
    assign last_s      = ucode_done_i | ((limit_r != '0) & (count_inc_s == limit_r));
    assign wd_expire_s = (TIMEOUT != 0) && (wd_r == WD_MAX);

    // State register; clear and reset override any pending transition.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and control outputs.
    always_comb begin
        state_next_s   = state_r;
        busy_o         = 1'b1;
        done_o         = 1'b0;
        err_o          = 1'b0;
        ucode_clear_o  = clear_i;
        ucode_enable_o = 1'b0;
        upd_valid_o    = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_next_s = S_CLEAR;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                ucode_clear_o = 1'b1;
                state_next_s  = S_RUN;
            end
            S_RUN: begin
                // The engine must not be stepped in the cycle its flags are consumed.
                ucode_enable_o = ~ucode_valid_i;
                if (ucode_valid_i) begin
                    state_next_s = S_OUT;
                end else if (wd_expire_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_OUT: begin
                upd_valid_o = 1'b1;
                if (upd_ready_i) begin
                    state_next_s = upd_last_o ? S_DONE : S_RUN;
                end else begin
                    state_next_s = S_OUT;
                end
            end
            S_DONE: begin
                done_o       = 1'b1;
                state_next_s = S_IDLE;
            end
            S_ERR: begin
                err_o         = 1'b1;
                ucode_clear_o = 1'b1;
                state_next_s  = S_ERR;
            end
            default: begin
                busy_o       = 1'b0;
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Job limit, update counter, watchdog and the one-entry output buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            limit_r     <= '0;
            upd_count_o <= '0;
            wd_r        <= '0;
            upd_offs_o  <= '0;
            upd_accum_o <= 1'b0;
            upd_last_o  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        limit_r     <= nb_updates_i;
                        upd_count_o <= '0;
                    end
                end
                S_CLEAR: wd_r <= '0;
                S_RUN: begin
                    if (ucode_valid_i) begin
                        upd_offs_o  <= ucode_offs_i;
                        upd_accum_o <= ucode_accum_i;
                        upd_last_o  <= last_s;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                S_OUT: begin
                    if (upd_ready_i) begin
                        upd_count_o <= count_inc_s;
                        wd_r        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hwpe_ctrl_ucode_sched.md
# hwpe_ctrl_ucode_sched

Scheduler that sequences the HWPE microcode loop engine for one job. On a start command it clears the engine, holds its enable until the engine reports a flags-valid step, captures the updated offsets/accum/done flags into a one-entry output buffer, and hands them to the streamer control via a valid/ready handshake. It repeats until the engine reports done or a programmed update count is reached. A watchdog flags a hung engine. Sits between the HWPE FSM and the microcode engine.

## Interface
- NB_REG, 4, number of engine offset registers forwarded
- REG_WIDTH, 32, width of each offset register
- CNT_WIDTH, 16, width of update counter and limit
- TIMEOUT, 1024, max cycles in RUN without ucode_valid_i; 0 disables watchdog

- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous soft clear, same effect as reset
- start_i  in  1  job start pulse, accepted only in IDLE
- nb_updates_i  in  CNT_WIDTH  update limit, sampled on accepted start; 0 = run until engine done
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on job completion
- err_o  out  1  sticky watchdog error
- ucode_clear_o  out  1  clear to engine
- ucode_enable_o  out  1  step enable to engine
- ucode_valid_i  in  1  engine flags valid
- ucode_done_i  in  1  engine done flag
- ucode_accum_i  in  1  engine accum flag
- ucode_offs_i  in  NB_REG*REG_WIDTH  engine offsets, reg i at bits [i*REG_WIDTH +: REG_WIDTH]
- upd_valid_o  out  1  update record valid
- upd_ready_i  in  1  consumer ready
- upd_offs_o  out  NB_REG*REG_WIDTH  captured offsets
- upd_accum_o  out  1  captured accum
- upd_last_o  out  1  record is last of job
- upd_count_o  out  CNT_WIDTH  completed handshakes this job

## Operation
- States: IDLE, CLEAR, RUN, OUT, DONE, ERR.
- IDLE: start_i -> CLEAR; latch nb_updates_i, zero count, clear err_o.
- CLEAR: ucode_clear_o=1 for one cycle -> RUN; watchdog counter zeroed.
- RUN: ucode_enable_o = ~ucode_valid_i (combinational; engine not stepped in the valid cycle). On ucode_valid_i: capture offs/accum into buffer; upd_last = ucode_done_i | (limit!=0 & count+1==limit); -> OUT.
- RUN watchdog: counter increments each RUN cycle without valid; when it equals TIMEOUT-1 without valid (TIMEOUT!=0) -> ERR.
- OUT: upd_valid_o=1, data stable until upd_valid_o & upd_ready_i. On handshake count+=1; if upd_last_o -> DONE, else -> RUN (watchdog re-zeroed).
- DONE: done_o=1 for one cycle -> IDLE.
- ERR: err_o=1, busy_o=1, ucode_clear_o=1; -> IDLE only via clear_i/rst_i. err_o then stays 0.
- ucode_valid_i outside RUN is ignored. start_i outside IDLE is ignored.
- Count wraps modulo 2^CNT_WIDTH; limit compare is exact equality.
- clear_i / rst_i win over every other event, including same-cycle start_i or handshake; no done_o pulse generated.
- ucode_clear_o = (state==CLEAR) | (state==ERR) | clear_i.

## Timing
- Reset/clear values: state IDLE; all outputs 0 (busy_o, done_o, err_o, ucode_enable_o, upd_valid_o, upd_offs_o, upd_accum_o, upd_last_o, upd_count_o); ucode_clear_o equals clear_i.
- start at cycle 0 -> busy_o and ucode_clear_o high cycle 1 -> ucode_enable_o high from cycle 2.
- ucode_valid_i at cycle k in RUN -> upd_valid_o high from k+1.
- Handshake at cycle m, not last -> ucode_enable_o high at m+1; last -> done_o at m+1, busy_o low at m+2.
- upd_ready_i may be high before upd_valid_o; the handshake completes in the first cycle of OUT.
- Minimum one record per 2 cycles (RUN, OUT).

## Test plan
- Basic: nb_updates_i=3, engine valid 4 cycles after each enable, ready tied 1, ucode_done_i=0 -> 3 records, upd_last_o on third, upd_count_o=3, done_o one cycle, enable never asserted in a valid cycle.
- Engine done: nb_updates_i=0, ucode_done_i=1 with 5th valid -> 5 records, last on 5th, done_o pulse.
- Backpressure: ready low 7 cycles during OUT -> upd_valid_o held, upd_offs_o/upd_accum_o stable, ucode_enable_o=0, count unchanged until handshake.
- Watchdog: TIMEOUT=16, no ucode_valid_i -> ERR after 16 RUN cycles, err_o=1, ucode_clear_o=1, start_i ignored; clear_i -> IDLE, err_o=0.
- Clear mid-job: clear_i during OUT with same-cycle ready -> next cycle IDLE, all outputs 0, count 0, no done_o.
- Ignored inputs: start_i during RUN and ucode_valid_i in IDLE -> no state change; start_i with clear_i in IDLE -> stays IDLE.
